// File: rtl/alarm_clock_pkg.sv
// Shared types for the alarm clock: field widths, sequencer states and the
// time-of-day record used by the alarm, time and sequencer blocks.
package alarm_clock_pkg;

    localparam int unsigned HOUR_W = 4;
    localparam int unsigned MIN_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic              pm;
    } clock_time_t;

    // Hours 0 stands for 12, so a plain field compare is sufficient.
    function automatic logic time_eq(input clock_time_t a, input clock_time_t b);
        return (a == b);
    endfunction

endpackage

// File: rtl/alarm_sequencer_tone_gen.sv
// Square-wave tone source: toggles every TONE_HALF clocks while enabled,
// held cleared (counter and output) while disabled.
module tone_gen #(
    parameter int unsigned TONE_HALF = 25000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tone
);

    localparam int unsigned CNT_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tone;

    // Half-period counter; tone flips at each wrap, everything clears when disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (r_cnt == CNT_W'(TONE_HALF - 1)) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tone = r_tone;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: detects the rising edge of alarm/time equality, then rings,
// snoozes, times out or stops, driving a beep-gated tone to the speaker.
module alarm_sequencer
    import alarm_clock_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned TONE_HALF  = 25000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sec_tick,
    input  logic              alarm_en,
    input  logic              snooze,
    input  logic              stop,
    input  logic [HOUR_W-1:0] alm_hours,
    input  logic [MIN_W-1:0]  alm_minutes,
    input  logic              alm_pm,
    input  logic [HOUR_W-1:0] time_hours,
    input  logic [MIN_W-1:0]  time_minutes,
    input  logic              time_pm,
    output logic              speaker,
    output logic              ringing,
    output logic              alarm_active,
    output logic [1:0]        snooze_cnt
);

    localparam int unsigned SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int unsigned SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

    alarm_state_t     r_state, w_state_nxt;
    logic [SEC_W-1:0] r_sec_cnt, w_sec_nxt;
    logic             r_beep, w_beep_nxt;
    logic [1:0]       r_snz_cnt, w_snz_nxt;
    logic             r_match_q;
    logic             r_seen_low;
    logic             r_speaker;
    logic             r_ringing;
    logic             r_active;

    clock_time_t      w_alarm_time;
    clock_time_t      w_now_time;
    logic             w_match;
    logic             w_trig;
    logic             w_tone;
    logic             w_tone_en;

    assign w_alarm_time = '{hours: alm_hours, minutes: alm_minutes, pm: alm_pm};
    assign w_now_time   = '{hours: time_hours, minutes: time_minutes, pm: time_pm};
    assign w_match      = time_eq(w_alarm_time, w_now_time);

    // r_seen_low blocks a trigger until match has been observed low once since
    // reset; match_q alone resets to 0 and would fire on a match already present.
    assign w_trig = w_match & ~r_match_q & r_seen_low & alarm_en;

    // Tone runs only while staying in RINGING, so it starts from a cleared
    // counter on entry and clears on the edge that leaves.
    assign w_tone_en = (r_state == RINGING) && (w_state_nxt == RINGING);

    tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_tone_en),
        .tone    (w_tone)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sec_cnt  <= '0;
            r_beep     <= 1'b0;
            r_snz_cnt  <= '0;
            r_match_q  <= 1'b0;
            r_seen_low <= 1'b0;
            r_speaker  <= 1'b0;
            r_ringing  <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sec_cnt  <= w_sec_nxt;
            r_beep     <= w_beep_nxt;
            r_snz_cnt  <= w_snz_nxt;
            r_match_q  <= w_match;
            r_seen_low <= r_seen_low | ~w_match;
            r_speaker  <= (w_state_nxt == RINGING) & w_tone & w_beep_nxt;
            r_ringing  <= (w_state_nxt == RINGING);
            r_active   <= (w_state_nxt == RINGING) || (w_state_nxt == SNOOZED);
        end
    end

    // Next-state logic: disable, stop, snooze, timeout in decreasing priority.
    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec_cnt;
        w_beep_nxt  = r_beep;
        w_snz_nxt   = r_snz_cnt;

        if (!alarm_en) begin
            w_state_nxt = IDLE;
            w_sec_nxt   = '0;
            w_beep_nxt  = 1'b0;
            w_snz_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        w_state_nxt = RINGING;
                        w_sec_nxt   = '0;
                        w_beep_nxt  = 1'b1;
                        w_snz_nxt   = '0;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        w_state_nxt = IDLE;
                        w_sec_nxt   = '0;
                        w_snz_nxt   = '0;
                    end else if (snooze && (r_snz_cnt < 2'(MAX_SNOOZE))) begin
                        w_state_nxt = SNOOZED;
                        w_sec_nxt   = '0;
                        w_snz_nxt   = r_snz_cnt + 2'd1;
                    end else if (sec_tick) begin
                        if (r_sec_cnt == SEC_W'(RING_SEC - 1)) begin
                            w_state_nxt = IDLE;
                            w_sec_nxt   = '0;
                            w_snz_nxt   = '0;
                        end else begin
                            w_sec_nxt  = r_sec_cnt + 1'b1;
                            w_beep_nxt = ~r_beep;
                        end
                    end
                end
                SNOOZED: begin
                    if (stop) begin
                        w_state_nxt = IDLE;
                        w_sec_nxt   = '0;
                        w_snz_nxt   = '0;
                    end else if (sec_tick) begin
                        if (r_sec_cnt == SEC_W'(SNOOZE_SEC - 1)) begin
                            w_state_nxt = RINGING;
                            w_sec_nxt   = '0;
                            w_beep_nxt  = 1'b1;
                        end else begin
                            w_sec_nxt = r_sec_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_sec_nxt   = '0;
                    w_snz_nxt   = '0;
                end
            endcase
        end
    end

    assign speaker      = r_speaker;
    assign ringing      = r_ringing;
    assign alarm_active = r_active;
    assign snooze_cnt   = r_snz_cnt;

endmodule
